// File: rtl/vending_fsm_cart.sv
// Vending controller: multi-slot cart, coin intake with saturation and reject,
// idle-timeout refund and greedy one-coin-per-press change dispensing.
//
// state   | meaning
// IDLE    | waiting for Confirm, money and cart held at zero
// SELECT  | building the cart with Goods / Cancel
// PAYMENT | accepting coins until Confirm covers the total
// TEMP    | cancel confirmation: Confirm refunds, Cancel returns to SELECT
// CHANGE  | one coin per Change press until nothing is owed
// DONE    | single-cycle cleanup before IDLE
module vending_fsm_cart #(
  parameter int                    CART_SLOTS  = 4,
  parameter int                    MONEY_W     = 9,
  parameter int                    PRICE_W     = 5,
  parameter logic [16*PRICE_W-1:0] PRICE_TABLE = {5'd5, 5'd5, 5'd4, 5'd9,
                                                  5'd8, 5'd15, 5'd6, 5'd4,
                                                  5'd7, 5'd9, 5'd8, 5'd10,
                                                  5'd3, 5'd6, 5'd4, 5'd3},
  parameter logic [31:0]           TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              sys_Goods,
  input  logic                              sys_Confirm,
  input  logic                              sys_Change,
  input  logic                              sys_Cancel,
  input  logic [4:0]                        coin_in,
  input  logic [2:0]                        type_SW_high,
  input  logic [2:0]                        type_SW_low,
  input  logic [1:0]                        num_SW,
  output logic [MONEY_W-1:0]                input_money,
  output logic [MONEY_W-1:0]                need_money,
  output logic [MONEY_W-1:0]                change_money,
  output logic [$clog2(CART_SLOTS+1)-1:0]   cart_count,
  output logic [4:0]                        coin_out,
  output logic                              coin_reject,
  output logic                              timeout_flag,
  output logic [5:0]                        state_out
);

  localparam int CNT_W = $clog2(CART_SLOTS + 1);

  localparam logic [5:0] S_IDLE    = 6'h01;
  localparam logic [5:0] S_SELECT  = 6'h02;
  localparam logic [5:0] S_PAYMENT = 6'h04;
  localparam logic [5:0] S_TEMP    = 6'h08;
  localparam logic [5:0] S_CHANGE  = 6'h10;
  localparam logic [5:0] S_DONE    = 6'h20;

  localparam logic [MONEY_W:0] MONEY_MAX = {1'b0, {MONEY_W{1'b1}}};

  logic [5:0]         state_q, state_d;
  logic [MONEY_W-1:0] cart_q [CART_SLOTS];
  logic [MONEY_W-1:0] cart_d [CART_SLOTS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MONEY_W-1:0] need_q, need_d;
  logic [MONEY_W-1:0] in_q, in_d;
  logic [MONEY_W-1:0] chg_q, chg_d;
  logic [4:0]         coin_out_q, coin_out_d;
  logic               rej_q, rej_d;
  logic               tmo_q, tmo_d;
  logic [31:0]        tmr_q, tmr_d;

  logic               code_ok, cart_full, coin_onehot, coin_fits, leave_pay;
  logic [1:0]         hi_m1, lo_m1;
  logic [3:0]         price_idx;
  logic [PRICE_W-1:0] unit_price;
  logic [MONEY_W-1:0] item_amt, last_amt, coin_val, chg_coin_val;
  logic [4:0]         chg_coin;
  logic [MONEY_W:0]   coin_sum;

  function automatic logic [MONEY_W-1:0] coin_value(input logic [4:0] c);
    logic [MONEY_W-1:0] v;
    case (c)
      5'b00001: v = MONEY_W'(1);
      5'b00010: v = MONEY_W'(5);
      5'b00100: v = MONEY_W'(10);
      5'b01000: v = MONEY_W'(20);
      5'b10000: v = MONEY_W'(50);
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Category/index 4 wraps to 3 in the low two bits, which is the table row/column we want.
  assign hi_m1      = type_SW_high[1:0] - 2'd1;
  assign lo_m1      = type_SW_low[1:0] - 2'd1;
  assign price_idx  = {hi_m1, lo_m1};
  assign unit_price = PRICE_TABLE[int'(price_idx)*PRICE_W +: PRICE_W];
  assign item_amt   = MONEY_W'(unit_price) * MONEY_W'(num_SW);
  assign code_ok    = (type_SW_high >= 3'd1) && (type_SW_high <= 3'd4) &&
                      (type_SW_low  >= 3'd1) && (type_SW_low  <= 3'd4);
  assign cart_full  = (cnt_q == CNT_W'(CART_SLOTS));

  assign coin_onehot = $onehot(coin_in);
  assign coin_val    = coin_value(coin_in);
  assign coin_sum    = {1'b0, in_q} + {1'b0, coin_val};
  assign coin_fits   = (coin_sum <= MONEY_MAX);

  always_comb begin
    last_amt = '0;
    for (int i = 0; i < CART_SLOTS; i++) begin
      if (cnt_q == CNT_W'(i + 1)) last_amt = cart_q[i];
    end
    if (chg_q >= MONEY_W'(50))      chg_coin = 5'b10000;
    else if (chg_q >= MONEY_W'(20)) chg_coin = 5'b01000;
    else if (chg_q >= MONEY_W'(10)) chg_coin = 5'b00100;
    else if (chg_q >= MONEY_W'(5))  chg_coin = 5'b00010;
    else                            chg_coin = 5'b00001;
    chg_coin_val = coin_value(chg_coin);
  end

  always_comb begin
    state_d    = state_q;
    cart_d     = cart_q;
    cnt_d      = cnt_q;
    need_d     = need_q;
    in_d       = in_q;
    chg_d      = chg_q;
    coin_out_d = 5'b0;
    rej_d      = (coin_in != 5'b0) && (state_q != S_PAYMENT);
    tmo_d      = tmo_q;
    tmr_d      = tmr_q;
    leave_pay  = 1'b0;

    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < CART_SLOTS; i++) cart_d[i] = '0;
        cnt_d  = '0;
        need_d = '0;
        in_d   = '0;
        chg_d  = '0;
        tmo_d  = 1'b0;
        if (!sys_Cancel && sys_Confirm) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sys_Cancel) begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            need_d = need_q - last_amt;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sys_Confirm) begin
          if (need_q != '0) begin
            state_d = S_PAYMENT;
            tmr_d   = TIMEOUT_CYC;
          end
        end else if (sys_Goods && code_ok && (num_SW != 2'd0) && !cart_full) begin
          for (int i = 0; i < CART_SLOTS; i++) begin
            if (cnt_q == CNT_W'(i)) cart_d[i] = item_amt;
          end
          cnt_d  = cnt_q + CNT_W'(1);
          need_d = need_q + item_amt;
        end
      end
      S_PAYMENT: begin
        if (sys_Cancel) begin
          state_d   = S_TEMP;
          leave_pay = 1'b1;
        end else if (sys_Confirm && (in_q >= need_q)) begin
          state_d   = S_CHANGE;
          chg_d     = in_q - need_q;
          leave_pay = 1'b1;
        end
        // A coin landing on the cycle we leave PAYMENT is handed back, not silently lost.
        if (leave_pay) begin
          rej_d = (coin_in != 5'b0);
        end else if (coin_in != 5'b0) begin
          tmr_d = TIMEOUT_CYC;
          if (coin_onehot && coin_fits) in_d = coin_sum[MONEY_W-1:0];
          else                          rej_d = 1'b1;
        end else if (TIMEOUT_CYC != 32'd0) begin
          if (tmr_q == 32'd1) begin
            state_d = S_CHANGE;
            chg_d   = in_q;
            need_d  = '0;
            tmo_d   = 1'b1;
          end else begin
            tmr_d = tmr_q - 32'd1;
          end
        end
      end
      S_TEMP: begin
        if (sys_Cancel) begin
          state_d = S_SELECT;
        end else if (sys_Confirm) begin
          state_d = S_CHANGE;
          chg_d   = in_q;
          need_d  = '0;
        end
      end
      S_CHANGE: begin
        if (sys_Change) begin
          if (chg_q != '0) begin
            coin_out_d = chg_coin;
            chg_d      = chg_q - chg_coin_val;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        for (int i = 0; i < CART_SLOTS; i++) cart_d[i] = '0;
        cnt_d   = '0;
        need_d  = '0;
        in_d    = '0;
        chg_d   = '0;
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < CART_SLOTS; i++) cart_q[i] <= '0;
      cnt_q      <= '0;
      need_q     <= '0;
      in_q       <= '0;
      chg_q      <= '0;
      coin_out_q <= 5'b0;
      rej_q      <= 1'b0;
      tmo_q      <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cart_q     <= cart_d;
      cnt_q      <= cnt_d;
      need_q     <= need_d;
      in_q       <= in_d;
      chg_q      <= chg_d;
      coin_out_q <= coin_out_d;
      rej_q      <= rej_d;
      tmo_q      <= tmo_d;
      tmr_q      <= tmr_d;
    end
  end

  assign input_money  = in_q;
  assign need_money   = need_q;
  assign change_money = chg_q;
  assign cart_count   = cnt_q;
  assign coin_out     = coin_out_q;
  assign coin_reject  = rej_q;
  assign timeout_flag = tmo_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_vending_fsm_cart.sv
// Bench for vending_fsm_cart: directed walk through the main flows, then random
// pulses compared every cycle against a queue-based behavioural model.
module tb_vending_fsm_cart;
  localparam int MW    = 9;
  localparam int SLOTS = 4;
  localparam int TMO   = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       sys_Goods = 1'b0, sys_Confirm = 1'b0, sys_Change = 1'b0, sys_Cancel = 1'b0;
  logic [4:0] coin_in = 5'b0;
  logic [2:0] type_SW_high = 3'd0, type_SW_low = 3'd0;
  logic [1:0] num_SW = 2'd0;

  logic [MW-1:0] input_money, need_money, change_money;
  logic [2:0]    cart_count;
  logic [4:0]    coin_out;
  logic          coin_reject, timeout_flag;
  logic [5:0]    state_out;

  logic [5:0] in2, need2, chg2;
  logic [2:0] cnt2;
  logic [4:0] cout2;
  logic       rej2, tmo2;
  logic [5:0] st2;

  always #5 sys_clk = ~sys_clk;

  vending_fsm_cart #(.CART_SLOTS(SLOTS), .MONEY_W(MW), .TIMEOUT_CYC(32'(TMO))) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_Goods(sys_Goods),
    .sys_Confirm(sys_Confirm), .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
    .coin_in(coin_in), .type_SW_high(type_SW_high), .type_SW_low(type_SW_low),
    .num_SW(num_SW), .input_money(input_money), .need_money(need_money),
    .change_money(change_money), .cart_count(cart_count), .coin_out(coin_out),
    .coin_reject(coin_reject), .timeout_flag(timeout_flag), .state_out(state_out));

  vending_fsm_cart #(.CART_SLOTS(SLOTS), .MONEY_W(6)) dut6 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_Goods(sys_Goods),
    .sys_Confirm(sys_Confirm), .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
    .coin_in(coin_in), .type_SW_high(type_SW_high), .type_SW_low(type_SW_low),
    .num_SW(num_SW), .input_money(in2), .need_money(need2),
    .change_money(chg2), .cart_count(cnt2), .coin_out(cout2),
    .coin_reject(rej2), .timeout_flag(tmo2), .state_out(st2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  typedef enum int {M_IDLE, M_SELECT, M_PAYMENT, M_TEMP, M_CHANGE, M_DONE} mst_t;
  mst_t ms = M_IDLE;
  int   cart[$];
  int   m_in = 0, m_chg = 0, m_idle = 0, m_coin_out = 0;
  bit   m_need_zero = 0, m_tmo = 0, m_rej = 0;
  int   cval [5] = '{1, 5, 10, 20, 50};
  int   price_tab [4][4] = '{'{3, 4, 6, 3}, '{10, 8, 9, 7}, '{4, 6, 15, 8}, '{9, 4, 5, 5}};

  function automatic int m_need();
    int s = 0;
    foreach (cart[i]) s += cart[i];
    return m_need_zero ? 0 : (s % (1 << MW));
  endfunction

  task automatic m_clear();
    cart.delete();
    m_in = 0; m_chg = 0; m_need_zero = 0; m_tmo = 0;
  endtask

  task automatic model_step(input bit rst, input bit g, input bit cf, input bit ch,
                            input bit cn, input logic [4:0] coin);
    bit b_cf, b_g, found;
    int h, l, n, v;
    m_coin_out = 0;
    m_rej = 0;
    if (rst) begin
      m_clear(); ms = M_IDLE; m_idle = 0;
      return;
    end
    b_cf = cf && !cn;
    b_g  = g && !cf && !cn;
    h = int'(type_SW_high); l = int'(type_SW_low); n = int'(num_SW);
    if (coin != 0 && ms != M_PAYMENT) m_rej = 1;
    case (ms)
      M_IDLE: begin
        m_clear();
        if (b_cf) ms = M_SELECT;
      end
      M_SELECT: begin
        if (cn) begin
          if (cart.size() > 0) void'(cart.pop_back());
          else ms = M_IDLE;
        end else if (b_cf) begin
          if (m_need() > 0) begin ms = M_PAYMENT; m_idle = 0; end
        end else if (b_g && h >= 1 && h <= 4 && l >= 1 && l <= 4 && n > 0 && cart.size() < SLOTS) begin
          cart.push_back(price_tab[h-1][l-1] * n);
        end
      end
      M_PAYMENT: begin
        if (cn) begin
          ms = M_TEMP; m_rej = (coin != 0);
        end else if (b_cf && m_in >= m_need()) begin
          m_chg = m_in - m_need(); ms = M_CHANGE; m_rej = (coin != 0);
        end else if (coin != 0) begin
          m_idle = 0;
          v = 0;
          for (int i = 0; i < 5; i++) if (coin[i]) v = cval[i];
          if ($countones(coin) == 1 && m_in + v <= (1 << MW) - 1) m_in += v;
          else m_rej = 1;
        end else if (TMO != 0) begin
          m_idle++;
          if (m_idle == TMO) begin
            ms = M_CHANGE; m_chg = m_in; m_need_zero = 1; m_tmo = 1;
          end
        end
      end
      M_TEMP: begin
        if (cn) ms = M_SELECT;
        else if (b_cf) begin ms = M_CHANGE; m_chg = m_in; m_need_zero = 1; end
      end
      M_CHANGE: begin
        if (ch) begin
          if (m_chg > 0) begin
            found = 0;
            for (int i = 4; i >= 0; i--) begin
              if (!found && cval[i] <= m_chg) begin
                found = 1; m_coin_out = 1 << i; m_chg -= cval[i];
              end
            end
          end else ms = M_DONE;
        end
      end
      default: begin
        m_clear(); ms = M_IDLE;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("state",   32'(state_out),    32'(1 << int'(ms)));
    chk("input",   32'(input_money),  32'(m_in));
    chk("need",    32'(need_money),   32'(m_need()));
    chk("change",  32'(change_money), 32'(m_chg));
    chk("count",   32'(cart_count),   32'(cart.size()));
    chk("coinout", 32'(coin_out),     32'(m_coin_out));
    chk("reject",  32'(coin_reject),  32'(m_rej));
    chk("timeout", 32'(timeout_flag), 32'(m_tmo));
  endtask

  task automatic sel(input int h, input int l, input int n);
    type_SW_high = 3'(h); type_SW_low = 3'(l); num_SW = 2'(n);
  endtask

  task automatic tick(input bit rst, input bit g, input bit cf, input bit ch,
                      input bit cn, input logic [4:0] coin);
    sys_rst_n = rst; sys_Goods = g; sys_Confirm = cf; sys_Change = ch;
    sys_Cancel = cn; coin_in = coin;
    model_step(rst, g, cf, ch, cn, coin);
    @(posedge sys_clk);
    #1;
    check_model();
    sys_rst_n = 0; sys_Goods = 0; sys_Confirm = 0; sys_Change = 0;
    sys_Cancel = 0; coin_in = 5'b0;
  endtask

  initial begin
    int r;
    bit rr, rg, rcf, rch, rcn;
    logic [4:0] rc;
    #2;
    // Reset and cart building
    sel(1, 3, 2);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(state_out), 32'h01);
    chk("rst_money", 32'(input_money + need_money + change_money), 0);
    tick(0, 0, 1, 0, 0, 0);
    chk("to_select", 32'(state_out), 32'h02);
    tick(0, 1, 0, 0, 0, 0);
    chk("need12", 32'(need_money), 12);
    chk("cnt1", 32'(cart_count), 1);
    sel(3, 3, 1); tick(0, 1, 0, 0, 0, 0);
    chk("need27", 32'(need_money), 27);
    sel(0, 2, 1); tick(0, 1, 0, 0, 0, 0);
    sel(2, 5, 1); tick(0, 1, 0, 0, 0, 0);
    sel(2, 1, 0); tick(0, 1, 0, 0, 0, 0);
    chk("invalid_ignored", 32'(need_money), 27);
    sel(2, 1, 1); tick(0, 1, 0, 0, 0, 0);
    sel(4, 4, 3); tick(0, 1, 0, 0, 0, 0);
    chk("need52", 32'(need_money), 52);
    sel(1, 1, 1); tick(0, 1, 0, 0, 0, 0);
    chk("full_cnt", 32'(cart_count), 4);
    chk("full_need", 32'(need_money), 52);
    tick(0, 0, 0, 0, 1, 0);
    chk("cancel_cnt", 32'(cart_count), 3);
    chk("cancel_need", 32'(need_money), 37);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 5'b00001);
    chk("coin_in_select_rej", 32'(coin_reject), 1);
    // Payment and change
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 5'b01000);
    tick(0, 0, 0, 0, 0, 5'b00100);
    chk("paid30", 32'(input_money), 30);
    tick(0, 0, 0, 0, 0, 5'b00011);
    chk("bad_coin_rej", 32'(coin_reject), 1);
    chk("bad_coin_money", 32'(input_money), 30);
    tick(0, 0, 1, 0, 0, 0);
    chk("change3", 32'(change_money), 3);
    repeat (3) begin
      tick(0, 0, 0, 1, 0, 0);
      chk("coin_one", 32'(coin_out), 32'b00001);
    end
    tick(0, 0, 0, 1, 0, 0);
    chk("done", 32'(state_out), 32'h20);
    tick(0, 0, 0, 0, 0, 0);
    chk("back_idle", 32'(state_out), 32'h01);
    // Idle timeout refund
    tick(0, 0, 1, 0, 0, 0);
    sel(1, 1, 1); tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 5'b00010);
    repeat (9) tick(0, 0, 0, 0, 0, 0);
    chk("pre_timeout", 32'(state_out), 32'h04);
    tick(0, 0, 0, 0, 0, 0);
    chk("timeout_state", 32'(state_out), 32'h10);
    chk("timeout_flag", 32'(timeout_flag), 1);
    chk("timeout_refund", 32'(change_money), 5);
    tick(0, 0, 0, 1, 0, 0);
    chk("coin_five", 32'(coin_out), 32'b00010);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("flag_cleared", 32'(timeout_flag), 0);
    // Cancel confirmation, then reset mid-change
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 5'b00001);
    tick(0, 0, 0, 0, 1, 0);
    chk("temp", 32'(state_out), 32'h08);
    tick(0, 0, 0, 0, 1, 0);
    chk("temp_back_cnt", 32'(cart_count), 1);
    chk("temp_back_in", 32'(input_money), 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 1, 0, 0, 0);
    chk("refund_chg", 32'(change_money), 1);
    chk("refund_need", 32'(need_money), 0);
    tick(1, 0, 0, 1, 0, 0);
    chk("midrst_state", 32'(state_out), 32'h01);
    chk("midrst_coin", 32'(coin_out), 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("postrst_coin", 32'(coin_out), 0);
    // Saturation on the 6-bit money instance
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    sel(1, 1, 1); tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 5'b10000);
    chk("w6_fifty", 32'(in2), 50);
    chk("w6_fifty_norej", 32'(rej2), 0);
    tick(0, 0, 0, 0, 0, 5'b01000);
    chk("w6_sat_rej", 32'(rej2), 1);
    chk("w6_sat_money", 32'(in2), 50);
    chk("w6_need", 32'(need2), 3);
    chk("w6_misc", 32'({st2, cnt2, cout2, tmo2, chg2}), 32'({6'h04, 3'd1, 5'd0, 1'b0, 6'd0}));
    // Randomised traffic
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 700; k++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rg  = ($urandom_range(0, 3) == 0);
      rcf = ($urandom_range(0, 4) == 0);
      rch = ($urandom_range(0, 2) == 0);
      rcn = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 9);
      if (r < 4)      rc = 5'b0;
      else if (r < 8) rc = 5'(1 << $urandom_range(0, 4));
      else            rc = 5'($urandom_range(0, 31));
      sel($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
      tick(rr, rg, rcf, rch, rcn, rc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
